// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: state encoding,
// default widths and the port-to-mask helper.
package sram_arb_pkg;

    localparam int ADDR_W_DEFAULT = 13;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } arb_state_t;

    // One-hot mask that hides the given port from arbitration.
    function automatic logic [1:0] port_mask(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side bundle of the arbiter; the slave modport is the
// arbiter's view, the master modport the requesters' and SRAM model's view.
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W_DEFAULT,
    parameter int DATA_WIDTH    = DATA_W_DEFAULT
);

    // Handshake: a port raises reqN_i with we/addr/wdata and holds all of them
    // stable until ackN_o pulses for one cycle; that pulse is the completion.
    logic                     req0_i;
    logic                     req0_we_i;
    logic [ADDRESS_WIDTH-1:0] req0_addr_i;
    logic [DATA_WIDTH-1:0]    req0_wdata_i;
    logic                     req1_i;
    logic                     req1_we_i;
    logic [ADDRESS_WIDTH-1:0] req1_addr_i;
    logic [DATA_WIDTH-1:0]    req1_wdata_i;
    logic                     ack0_o;
    logic                     ack1_o;
    logic [DATA_WIDTH-1:0]    rdata_o;
    logic                     busy_o;
    logic [ADDRESS_WIDTH-1:0] sram_address_o;
    logic [DATA_WIDTH-1:0]    sram_datain_o;
    logic                     sram_cs_o;
    logic                     sram_we_o;
    logic [DATA_WIDTH-1:0]    sram_dataout_i;
    arb_state_t               dbg_state;

    modport slave (
        input  req0_i, req0_we_i, req0_addr_i, req0_wdata_i,
        input  req1_i, req1_we_i, req1_addr_i, req1_wdata_i,
        input  sram_dataout_i,
        output ack0_o, ack1_o, rdata_o, busy_o,
        output sram_address_o, sram_datain_o, sram_cs_o, sram_we_o,
        output dbg_state
    );

    modport master (
        output req0_i, req0_we_i, req0_addr_i, req0_wdata_i,
        output req1_i, req1_we_i, req1_addr_i, req1_wdata_i,
        output sram_dataout_i,
        input  ack0_o, ack1_o, rdata_o, busy_o,
        input  sram_address_o, sram_datain_o, sram_cs_o, sram_we_o,
        input  dbg_state
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select: masked requests drop out, a lone
// requester wins, and a tie goes to the port not served last.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] mask,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    logic [1:0] eligible;

    always_comb begin
        eligible = {req1, req0} & ~mask;
        valid    = |eligible;
        winner   = 1'b0;
        case (eligible)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: grants one access at a time and sequences it
// through SETUP, STROBE (chip select low) and HOLD (ack).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W_DEFAULT,
    parameter int DATA_WIDTH    = DATA_W_DEFAULT
) (
    input  logic          sram_arbiter_clk_i,
    input  logic          sram_arbiter_rst_i,
    sram_arbiter_if.slave bus
);

    arb_state_t               state;
    arb_state_t               state_next;
    logic                     grant;
    logic                     last_ptr;
    logic                     op_we;
    logic [ADDRESS_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0]    op_wdata;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               arb_mask;
    logic                     arb_valid;
    logic                     arb_winner;
    logic                     take;

    // In HOLD the port just served is hidden so a waiting peer can follow
    // back-to-back, while a lone repeater has to pass through IDLE.
    assign arb_mask = (state == ST_HOLD) ? port_mask(grant) : 2'b00;

    rr_arb2 u_rr_arb2 (
        .req0   (bus.req0_i),
        .req1   (bus.req1_i),
        .mask   (arb_mask),
        .last   (last_ptr),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_next = ST_SETUP;
                    take       = 1'b1;
                end
            end
            ST_SETUP:  state_next = ST_STROBE;
            ST_STROBE: state_next = ST_HOLD;
            ST_HOLD: begin
                if (arb_valid) begin
                    state_next = ST_SETUP;
                    take       = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sram_arbiter_clk_i) begin
        if (sram_arbiter_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge sram_arbiter_clk_i) begin
        if (sram_arbiter_rst_i) begin
            grant    <= 1'b0;
            last_ptr <= 1'b1;
            op_we    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            rdata    <= '0;
        end else begin
            if (take) begin
                grant    <= arb_winner;
                op_we    <= arb_winner ? bus.req1_we_i    : bus.req0_we_i;
                op_addr  <= arb_winner ? bus.req1_addr_i  : bus.req0_addr_i;
                op_wdata <= arb_winner ? bus.req1_wdata_i : bus.req0_wdata_i;
            end
            // The pointer moves only on completion, so an aborted access
            // never counts as served.
            if (state == ST_HOLD) begin
                last_ptr <= grant;
            end
            if (state == ST_STROBE && !op_we) begin
                rdata <= bus.sram_dataout_i;
            end
        end
    end

    // Ack is suppressed while reset is asserted so an aborted HOLD is never acked.
    assign bus.ack0_o         = (state == ST_HOLD) && !grant && !sram_arbiter_rst_i;
    assign bus.ack1_o         = (state == ST_HOLD) &&  grant && !sram_arbiter_rst_i;
    assign bus.busy_o         = (state != ST_IDLE);
    assign bus.sram_cs_o      = (state != ST_STROBE);
    assign bus.sram_we_o      = !((state == ST_STROBE) && op_we);
    assign bus.sram_address_o = op_addr;
    assign bus.sram_datain_o  = op_wdata;
    assign bus.rdata_o        = rdata;
    assign bus.dbg_state      = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random traffic,
// with per-port expected queues checked by a monitor against a reference memory.
`timescale 1ns/1ps
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int EW = 1 + AW + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    sram_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .sram_arbiter_clk_i (clk),
        .sram_arbiter_rst_i (rst),
        .bus                (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model (64 words, aliased) ----------------
    logic [DW-1:0] sram_mem [64];
    logic [DW-1:0] ref_mem  [64];

    always @(posedge clk) begin
        if (!bus.sram_cs_o && !bus.sram_we_o)
            sram_mem[bus.sram_address_o[5:0]] <= bus.sram_datain_o;
    end
    assign bus.sram_dataout_i = sram_mem[bus.sram_address_o[5:0]];

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int            ack_port[$];
    int            ack_cyc[$];
    int            strobe_cnt = 0;
    int            strobe_cyc = 0;
    logic          strobe_we;
    logic [AW-1:0] strobe_addr;
    logic [DW-1:0] strobe_data;
    logic [EW-1:0] mon_e;
    int            mon_p;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            strobe_cnt = 0;
        end else begin
            if (!bus.sram_cs_o) begin
                strobe_cnt++;
                strobe_cyc  = cyc;
                strobe_we   = !bus.sram_we_o;
                strobe_addr = bus.sram_address_o;
                strobe_data = bus.sram_datain_o;
            end
            if (bus.ack0_o || bus.ack1_o) begin
                mon_p = bus.ack1_o ? 1 : 0;
                check("ack_overlap", {63'd0, bus.ack0_o & bus.ack1_o}, 64'd0);
                ack_port.push_back(mon_p);
                ack_cyc.push_back(cyc);
                check("ack_expected", {63'd0, (mon_p == 0) ? exp_q0.size() > 0 : exp_q1.size() > 0}, 64'd1);
                if ((mon_p == 0 && exp_q0.size() > 0) || (mon_p == 1 && exp_q1.size() > 0)) begin
                    mon_e = (mon_p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check("strobe_cnt", strobe_cnt, 1);
                    check("strobe_we", {63'd0, strobe_we}, {63'd0, mon_e[EW-1]});
                    check("strobe_addr", {51'd0, strobe_addr}, {51'd0, mon_e[EW-2 -: AW]});
                    if (mon_e[EW-1])
                        check("strobe_data", {32'd0, strobe_data}, {32'd0, mon_e[DW-1:0]});
                    else
                        check("rdata", {32'd0, bus.rdata_o}, {32'd0, mon_e[DW-1:0]});
                    check("busy_at_ack", {63'd0, bus.busy_o}, 64'd1);
                end
                strobe_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int p, input logic on, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (p == 0) begin
            bus.req0_i = on; bus.req0_we_i = we; bus.req0_addr_i = addr; bus.req0_wdata_i = data;
        end else begin
            bus.req1_i = on; bus.req1_we_i = we; bus.req1_addr_i = addr; bus.req1_wdata_i = data;
        end
    endtask

    // Reference model: a write updates the shadow memory, a read expects its contents.
    task automatic expect_push(input int p, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic [DW-1:0] d;
        if (we) begin
            ref_mem[addr[5:0]] = data;
            d = data;
        end else begin
            d = ref_mem[addr[5:0]];
        end
        if (p == 0) exp_q0.push_back({we, addr, d});
        else        exp_q1.push_back({we, addr, d});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1ns after a rising edge; returns 1ns after the edge leaving HOLD.
    task automatic access(input int p, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic keep,
                          output int t_start, output int t_ack);
        int   n;
        logic got;
        expect_push(p, we, addr, data);
        set_req(p, 1'b1, we, addr, data);
        t_start = cyc;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = (p == 0) ? bus.ack0_o : bus.ack1_o;
        end
        check($sformatf("ack_seen_p%0d", p), {63'd0, got}, 64'd1);
        t_ack = cyc;
        @(posedge clk);
        #1;
        if (!keep) set_req(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic clear_log();
        ack_port.delete();
        ack_cyc.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int ts, ta, ts2, ta2;
        logic [DW-1:0] v;

        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        idle(3);

        // Reset state
        @(negedge clk);
        check("rst_cs", {63'd0, bus.sram_cs_o}, 64'd1);
        check("rst_we", {63'd0, bus.sram_we_o}, 64'd1);
        check("rst_addr", {51'd0, bus.sram_address_o}, 64'd0);
        check("rst_datain", {32'd0, bus.sram_datain_o}, 64'd0);
        check("rst_rdata", {32'd0, bus.rdata_o}, 64'd0);
        check("rst_acks", {62'd0, bus.ack1_o, bus.ack0_o}, 64'd0);
        check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
        check("rst_state", {62'd0, bus.dbg_state}, {62'd0, ST_IDLE});
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write from port 1
        access(1, 1'b1, 13'h005, 32'hDEADBEEF, 1'b0, ts, ta);
        check("wr_ack_latency", ta - ts, 3);
        check("wr_strobe_cycle", strobe_cyc, ts + 2);

        // Read-back from port 0, rdata held afterwards
        access(0, 1'b0, 13'h005, 32'h0, 1'b0, ts, ta);
        check("rd_ack_latency", ta - ts, 3);
        idle(3);
        check("rdata_held_idle", {32'd0, bus.rdata_o}, 64'hDEADBEEF);
        access(1, 1'b1, 13'h1FFF, 32'hFFFFFFFF, 1'b0, ts, ta);
        idle(2);
        check("rdata_held_write", {32'd0, bus.rdata_o}, 64'hDEADBEEF);
        check("addr_held_idle", {51'd0, bus.sram_address_o}, 64'h1FFF);
        check("datain_held_idle", {32'd0, bus.sram_datain_o}, 64'hFFFFFFFF);
        access(0, 1'b0, 13'h1FFF, 32'h0, 1'b0, ts, ta);

        // Contention: simultaneous requests, two accesses each
        do_reset();
        clear_log();
        fork
            begin
                access(0, 1'b1, 13'h010, $urandom, 1'b1, ts, ta);
                access(0, 1'b1, 13'h011, $urandom, 1'b0, ts, ta);
            end
            begin
                access(1, 1'b1, 13'h030, $urandom, 1'b1, ts2, ta2);
                access(1, 1'b1, 13'h031, $urandom, 1'b0, ts2, ta2);
            end
        join
        check("cont_ack_count", ack_port.size(), 4);
        if (ack_port.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("cont_grant_%0d", i), ack_port[i], i % 2);
            for (int i = 1; i < 4; i++)
                check($sformatf("cont_spacing_%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
        end

        // Port 1 pulses for one cycle during port 0's STROBE: no access
        idle(2);
        clear_log();
        fork
            access(0, 1'b0, 13'h010, 32'h0, 1'b0, ts, ta);
            begin
                idle(2);
                check("pulse_in_strobe", {63'd0, bus.sram_cs_o}, 64'd0);
                set_req(1, 1'b1, 1'b1, 13'h033, 32'h12345678);
                idle(1);
                set_req(1, 1'b0, 1'b0, '0, '0);
            end
        join
        idle(6);
        check("withdraw_ack_count", ack_port.size(), 1);
        check("withdraw_mem_untouched", {32'd0, sram_mem[6'h33]}, {32'd0, ref_mem[6'h33]});

        // Lone port 0 repeating
        clear_log();
        access(0, 1'b1, 13'h012, $urandom, 1'b1, ts, ta);
        access(0, 1'b0, 13'h012, 32'h0, 1'b1, ts, ta);
        access(0, 1'b1, 13'h013, $urandom, 1'b0, ts, ta);
        check("lone_ack_count", ack_port.size(), 3);
        if (ack_port.size() == 3) begin
            for (int i = 1; i < 3; i++)
                check($sformatf("lone_spacing_%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);
        end

        // Reset during STROBE of a port 0 read, then a tie
        idle(2);
        clear_log();
        set_req(0, 1'b1, 1'b0, 13'h014, 32'h0);
        idle(2);
        check("abort_in_strobe", {63'd0, bus.sram_cs_o}, 64'd0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("abort_cs", {63'd0, bus.sram_cs_o}, 64'd1);
        check("abort_busy", {63'd0, bus.busy_o}, 64'd0);
        check("abort_ack0", {63'd0, bus.ack0_o}, 64'd0);
        check("abort_rdata", {32'd0, bus.rdata_o}, 64'd0);
        idle(4);
        check("abort_no_ack", ack_port.size(), 0);
        fork
            access(0, 1'b1, 13'h015, $urandom, 1'b0, ts, ta);
            access(1, 1'b1, 13'h035, $urandom, 1'b0, ts2, ta2);
        join
        check("post_reset_tie_count", ack_port.size(), 2);
        if (ack_port.size() == 2) check("post_reset_tie_winner", ack_port[0], 0);

        // Random traffic on disjoint address ranges with random upper bits
        idle(2);
        fork
            for (int k = 0; k < 30; k++) begin
                int s0, a0;
                logic kp0;
                kp0 = (k != 29) && ($urandom_range(0, 1) == 1);
                access(0, $urandom_range(0, 1) == 1,
                       {7'($urandom_range(0, 127)), 6'($urandom_range(0, 31))},
                       $urandom, kp0, s0, a0);
                if (!kp0) idle($urandom_range(0, 3));
            end
            for (int k = 0; k < 30; k++) begin
                int s1, a1;
                logic kp1;
                kp1 = (k != 29) && ($urandom_range(0, 1) == 1);
                access(1, $urandom_range(0, 1) == 1,
                       {7'($urandom_range(0, 127)), 6'($urandom_range(32, 63))},
                       $urandom, kp1, s1, a1);
                if (!kp1) idle($urandom_range(0, 3));
            end
        join

        idle(5);
        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);
        check("final_busy", {63'd0, bus.busy_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
